// File: rtl/layer_seq.sv
// layer_seq: CPU-programmed sequencer that streams per-neuron parameter and start
// writes to a downstream dot-product/activation slave, then fences on its completion.

module layer_seq (
   input  logic        clk,
   input  logic        rst_n,
   // CPU-facing slave port
   output logic        slave_waitrequest,
   input  logic [3:0]  slave_address,
   input  logic        slave_read,
   input  logic        slave_write,
   output logic [31:0] slave_readdata,
   input  logic [31:0] slave_writedata,
   // downstream master port
   input  logic        master_waitrequest,
   output logic [3:0]  master_address,
   output logic        master_write,
   output logic        master_read,
   output logic [31:0] master_writedata,
   input  logic [31:0] master_readdata
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WPARAM,
      S_WSTART,
      S_NEXT,
      S_FENCE
   } state_e;

   state_e      state_q, state_d;

   logic [31:0] bias_base_q, bias_base_d;
   logic [31:0] weight_base_q, weight_base_d;
   logic [31:0] in_base_q, in_base_d;
   logic [31:0] out_base_q, out_base_d;
   logic [31:0] len_q, len_d;
   logic [31:0] n_out_q, n_out_d;
   logic [31:0] relu_q, relu_d;

   logic [31:0] bias_ptr_q, bias_ptr_d;
   logic [31:0] w_ptr_q, w_ptr_d;
   logic [31:0] out_ptr_q, out_ptr_d;
   logic [31:0] remaining_q, remaining_d;
   logic [31:0] count_q, count_d;
   logic [2:0]  idx_q, idx_d;
   logic        first_q, first_d;
   logic        done_q, done_d;
   logic        err_q, err_d;

   logic        busy;
   logic        start_acc;
   logic        start_go;
   logic        cfg_we;
   logic        m_acc;
   logic        last_param;
   logic [3:0]  param_addr;

   // The CPU read strobe and downstream read data carry no information here.
   logic        unused_inputs;
   assign unused_inputs = ^{slave_read, master_readdata};

   // Register index of the idx-th parameter write; later neurons only refresh the moving pointers.
   function automatic logic [3:0] param_addr_f(input logic [2:0] idx, input logic first);
      logic [3:0] a;
      a = 4'd4;
      if (first) begin
         unique case (idx)
            3'd0:    a = 4'd1;
            3'd1:    a = 4'd2;
            3'd2:    a = 4'd3;
            3'd3:    a = 4'd4;
            3'd4:    a = 4'd5;
            default: a = 4'd7;
         endcase
      end else begin
         unique case (idx)
            3'd0:    a = 4'd1;
            3'd1:    a = 4'd2;
            default: a = 4'd4;
         endcase
      end
      return a;
   endfunction

   assign busy              = (state_q != S_IDLE);
   assign slave_waitrequest = busy & slave_write;
   assign start_acc         = (state_q == S_IDLE) && slave_write && (slave_address == 4'd0);
   assign start_go          = start_acc && (len_q != 32'd0) && (n_out_q != 32'd0);
   assign cfg_we            = (state_q == S_IDLE) && slave_write && (slave_address != 4'd0);
   assign m_acc             = ~master_waitrequest;
   assign param_addr        = param_addr_f(idx_q, first_q);
   assign last_param        = first_q ? (idx_q == 3'd5) : (idx_q == 3'd2);

   // ---------------------------------------------------------------- state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
      end else begin
         // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
         state_q <= state_d;
      end
   end

   // ---------------------------------------------------------------- next state
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:   if (start_go) state_d = S_WPARAM;
         S_WPARAM: if (m_acc && last_param) state_d = S_WSTART;
         S_WSTART: if (m_acc) state_d = S_NEXT;
         S_NEXT:   state_d = (remaining_q != 32'd0) ? S_WPARAM : S_FENCE;
         S_FENCE:  if (m_acc) state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   // ---------------------------------------------------------------- master outputs
   always_comb begin
      master_write     = 1'b0;
      master_read      = 1'b0;
      master_address   = 4'd0;
      master_writedata = 32'd0;
      unique case (state_q)
         S_WPARAM: begin
            master_write   = 1'b1;
            master_address = param_addr;
            unique case (param_addr)
               4'd1:    master_writedata = bias_ptr_q;
               4'd2:    master_writedata = w_ptr_q;
               4'd3:    master_writedata = in_base_q;
               4'd4:    master_writedata = out_ptr_q;
               4'd5:    master_writedata = len_q;
               default: master_writedata = relu_q;
            endcase
         end
         S_WSTART: master_write = 1'b1;
         S_FENCE:  master_read  = 1'b1;
         default:  ;
      endcase
   end

   // ---------------------------------------------------------------- datapath next values
   always_comb begin
      // NOTE: every variable gets its hold value first, so no path through this block infers a latch.
      bias_base_d   = bias_base_q;
      weight_base_d = weight_base_q;
      in_base_d     = in_base_q;
      out_base_d    = out_base_q;
      len_d         = len_q;
      n_out_d       = n_out_q;
      relu_d        = relu_q;
      bias_ptr_d    = bias_ptr_q;
      w_ptr_d       = w_ptr_q;
      out_ptr_d     = out_ptr_q;
      remaining_d   = remaining_q;
      count_d       = count_q;
      idx_d         = idx_q;
      first_d       = first_q;
      done_d        = done_q;
      err_d         = err_q;

      if (cfg_we) begin
         unique case (slave_address)
            4'd1:    bias_base_d   = slave_writedata;
            4'd2:    weight_base_d = slave_writedata;
            4'd3:    in_base_d     = slave_writedata;
            4'd4:    out_base_d    = slave_writedata;
            4'd5:    len_d         = slave_writedata;
            4'd6:    n_out_d       = slave_writedata;
            4'd7:    relu_d        = slave_writedata;
            default: ;
         endcase
      end

      // A degenerate start reports completion at once; err flags an empty neuron, not an empty layer.
      if (start_acc) begin
         done_d = ~start_go;
         err_d  = start_go ? 1'b0 : ((len_q == 32'd0) && (n_out_q != 32'd0));
      end

      if (start_go) begin
         count_d     = 32'd0;
         bias_ptr_d  = bias_base_q;
         w_ptr_d     = weight_base_q;
         out_ptr_d   = out_base_q;
         remaining_d = n_out_q;
         idx_d       = 3'd0;
         first_d     = 1'b1;
      end

      unique case (state_q)
         S_WPARAM: if (m_acc) idx_d = last_param ? 3'd0 : idx_q + 3'd1;
         S_WSTART: begin
            if (m_acc) begin
               count_d     = count_q + 32'd1;
               remaining_d = remaining_q - 32'd1;
            end
         end
         S_NEXT: begin
            bias_ptr_d = bias_ptr_q + 32'd4;
            out_ptr_d  = out_ptr_q + 32'd4;
            w_ptr_d    = w_ptr_q + (len_q << 2);
            first_d    = 1'b0;
            idx_d      = 3'd0;
         end
         S_FENCE:  if (m_acc) done_d = 1'b1;
         default:  ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bias_base_q   <= '0;
         weight_base_q <= '0;
         in_base_q     <= '0;
         out_base_q    <= '0;
         len_q         <= '0;
         n_out_q       <= '0;
         relu_q        <= '0;
         bias_ptr_q    <= '0;
         w_ptr_q       <= '0;
         out_ptr_q     <= '0;
         remaining_q   <= '0;
         count_q       <= '0;
         idx_q         <= '0;
         first_q       <= 1'b0;
         done_q        <= 1'b0;
         err_q         <= 1'b0;
      end else begin
         bias_base_q   <= bias_base_d;
         weight_base_q <= weight_base_d;
         in_base_q     <= in_base_d;
         out_base_q    <= out_base_d;
         len_q         <= len_d;
         n_out_q       <= n_out_d;
         relu_q        <= relu_d;
         bias_ptr_q    <= bias_ptr_d;
         w_ptr_q       <= w_ptr_d;
         out_ptr_q     <= out_ptr_d;
         remaining_q   <= remaining_d;
         count_q       <= count_d;
         idx_q         <= idx_d;
         first_q       <= first_d;
         done_q        <= done_d;
         err_q         <= err_d;
      end
   end

   // ---------------------------------------------------------------- CPU read mux
   always_comb begin
      slave_readdata = 32'd0;
      unique case (slave_address)
         4'd0:    slave_readdata = {29'd0, err_q, done_q, busy};
         4'd1:    slave_readdata = bias_base_q;
         4'd2:    slave_readdata = weight_base_q;
         4'd3:    slave_readdata = in_base_q;
         4'd4:    slave_readdata = out_base_q;
         4'd5:    slave_readdata = len_q;
         4'd6:    slave_readdata = n_out_q;
         4'd7:    slave_readdata = relu_q;
         4'd8:    slave_readdata = count_q;
         default: slave_readdata = 32'd0;
      endcase
   end

endmodule

// File: tb/tb_layer_seq.sv
// Directed testbench for layer_seq: register-map vectors, expected master-transaction
// tables, back-pressure, degenerate starts, pointer wrap, CPU stall and mid-run reset.

module tb_layer_seq;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        slave_waitrequest;
   logic [3:0]  slave_address;
   logic        slave_read;
   logic        slave_write;
   logic [31:0] slave_readdata;
   logic [31:0] slave_writedata;
   logic        master_waitrequest;
   logic [3:0]  master_address;
   logic        master_write;
   logic        master_read;
   logic [31:0] master_writedata;
   logic [31:0] master_readdata;

   layer_seq dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .slave_waitrequest (slave_waitrequest),
      .slave_address     (slave_address),
      .slave_read        (slave_read),
      .slave_write       (slave_write),
      .slave_readdata    (slave_readdata),
      .slave_writedata   (slave_writedata),
      .master_waitrequest(master_waitrequest),
      .master_address    (master_address),
      .master_write      (master_write),
      .master_read       (master_read),
      .master_writedata  (master_writedata),
      .master_readdata   (master_readdata)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        rd;
      logic [3:0]  addr;
      logic [31:0] data;
   } txn_t;

   typedef struct {
      logic [3:0]  addr;
      logic [31:0] wdata;
      logic [31:0] rexp;
   } reg_vec_t;

   int   tests = 0;
   int   failed = 0;
   txn_t txq[$];
   txn_t exp_q[$];
   txn_t seq_a[12];
   reg_vec_t reg_vec[10];

   int          stall_mode = 0;   // 0 none, 1 five cycles on each start write, 2 forever on start writes
   int          scnt = 0;
   int          stall_cycles = 0;
   int          stab_err = 0;
   int          both_err = 0;
   int          strobe_cnt = 0;
   logic        hold_prev = 1'b0;
   logic [3:0]  hold_a = '0;
   logic [31:0] hold_d = '0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Downstream model: drives back-pressure and records the transfer completing at the next posedge.
   always @(negedge clk) begin
      if (!rst_n) begin
         master_waitrequest = 1'b0;
         hold_prev          = 1'b0;
         scnt               = 0;
      end else begin
         if (stall_mode != 0 && master_write && master_address == 4'd0) begin
            if (stall_mode == 2 || scnt < 5) begin
               master_waitrequest = 1'b1;
               scnt++;
               stall_cycles++;
            end else begin
               master_waitrequest = 1'b0;
            end
         end else begin
            master_waitrequest = 1'b0;
            scnt               = 0;
         end
         if (master_write || master_read) strobe_cnt++;
         if (master_write && master_read) both_err++;
         if (hold_prev && (!master_write || master_address !== hold_a || master_writedata !== hold_d))
            stab_err++;
         hold_prev = master_write && master_waitrequest;
         hold_a    = master_address;
         hold_d    = master_writedata;
         if ((master_write || master_read) && !master_waitrequest) begin
            txn_t t;
            t.rd   = master_read;
            t.addr = master_address;
            t.data = master_writedata;
            txq.push_back(t);
         end
      end
   end

   task automatic cpu_write(input logic [3:0] a, input logic [31:0] d);
      int n = 0;
      @(negedge clk);
      slave_address   = a;
      slave_writedata = d;
      slave_write     = 1'b1;
      while (slave_waitrequest && n < 3000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 3000) check("cpu_write_timeout", 64'(n), 64'd0);
      @(posedge clk);
      #1;
      slave_write   = 1'b0;
      slave_address = 4'd0;
   endtask

   task automatic configure(input logic [31:0] b, input logic [31:0] w, input logic [31:0] i,
                            input logic [31:0] o, input logic [31:0] len, input logic [31:0] n,
                            input logic [31:0] relu);
      cpu_write(4'd1, b);
      cpu_write(4'd2, w);
      cpu_write(4'd3, i);
      cpu_write(4'd4, o);
      cpu_write(4'd5, len);
      cpu_write(4'd6, n);
      cpu_write(4'd7, relu);
   endtask

   task automatic wait_done(input string name);
      int n = 0;
      slave_address = 4'd0;
      @(negedge clk);
      while (slave_readdata[0] && n < 3000) begin
         @(negedge clk);
         n++;
      end
      check({name, "_done_in_time"}, 64'(n < 3000), 64'd1);
   endtask

   task automatic check_txns(input string name);
      check({name, "_txn_count"}, 64'(txq.size()), 64'(exp_q.size()));
      for (int i = 0; i < exp_q.size(); i++) begin
         if (i < txq.size())
            check($sformatf("%s_txn%0d", name, i),
                  {27'd0, txq[i].rd, txq[i].addr, txq[i].data},
                  {27'd0, exp_q[i].rd, exp_q[i].addr, exp_q[i].data});
      end
   endtask

   task automatic read_check(input string name, input logic [3:0] a, input logic [31:0] exp);
      slave_address = a;
      #1;
      check(name, 64'(slave_readdata), 64'(exp));
      slave_address = 4'd0;
   endtask

   task automatic load_seq_a();
      exp_q.delete();
      foreach (seq_a[i]) exp_q.push_back(seq_a[i]);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;

      seq_a = '{'{1'b0, 4'd1, 32'h100},  '{1'b0, 4'd2, 32'h1000}, '{1'b0, 4'd3, 32'h2000},
                '{1'b0, 4'd4, 32'h3000}, '{1'b0, 4'd5, 32'd4},    '{1'b0, 4'd7, 32'd1},
                '{1'b0, 4'd0, 32'd0},    '{1'b0, 4'd1, 32'h104},  '{1'b0, 4'd2, 32'h1010},
                '{1'b0, 4'd4, 32'h3004}, '{1'b0, 4'd0, 32'd0},    '{1'b1, 4'd0, 32'd0}};

      reg_vec = '{'{4'd1, 32'h1111_1111, 32'h1111_1111}, '{4'd2, 32'h2222_2222, 32'h2222_2222},
                  '{4'd3, 32'h3333_3333, 32'h3333_3333}, '{4'd4, 32'h4444_4444, 32'h4444_4444},
                  '{4'd5, 32'h0000_0055, 32'h0000_0055}, '{4'd6, 32'h0000_0066, 32'h0000_0066},
                  '{4'd7, 32'h0000_0001, 32'h0000_0001}, '{4'd8, 32'h0000_0005, 32'h0000_0000},
                  '{4'd9, 32'h0000_dead, 32'h0000_0000}, '{4'd15, 32'h1234_5678, 32'h0000_0000}};

      rst_n              = 1'b0;
      slave_address      = 4'd0;
      slave_read         = 1'b0;
      slave_write        = 1'b0;
      slave_writedata    = 32'd0;
      master_waitrequest = 1'b0;
      master_readdata    = 32'hA5A5_A5A5;

      // ---------------- reset state
      repeat (3) @(negedge clk);
      check("rst_status", 64'(slave_readdata), 64'd0);
      check("rst_strobes", 64'({master_write, master_read}), 64'd0);
      check("rst_maddr", 64'(master_address), 64'd0);
      check("rst_mdata", 64'(master_writedata), 64'd0);
      rst_n = 1'b1;

      // ---------------- register map vectors, no master traffic allowed
      txq.delete();
      strobe_cnt = 0;
      for (int i = 0; i < 10; i++) begin
         cpu_write(reg_vec[i].addr, reg_vec[i].wdata);
         read_check($sformatf("regmap_%0d", reg_vec[i].addr), reg_vec[i].addr, reg_vec[i].rexp);
      end
      check("regmap_no_master_traffic", 64'(strobe_cnt), 64'd0);

      // ---------------- basic two-neuron run, zero wait
      configure(32'h100, 32'h1000, 32'h2000, 32'h3000, 32'd4, 32'd2, 32'd1);
      txq.delete();
      cpu_write(4'd0, 32'd0);
      check("basic_first_write_next_cycle", 64'({master_write, master_address}), 64'h11);
      check("basic_busy", 64'(slave_readdata), 64'd1);
      wait_done("basic");
      load_seq_a();
      check_txns("basic");
      read_check("basic_status", 4'd0, 32'b010);
      read_check("basic_count", 4'd8, 32'd2);

      // ---------------- back-pressure on start writes
      stall_mode   = 1;
      stall_cycles = 0;
      stab_err     = 0;
      txq.delete();
      cpu_write(4'd0, 32'd0);
      wait_done("stall");
      stall_mode = 0;
      check_txns("stall");
      check("stall_cycles", 64'(stall_cycles), 64'd10);
      check("stall_held_stable", 64'(stab_err), 64'd0);
      read_check("stall_count", 4'd8, 32'd2);

      // ---------------- degenerate starts
      cpu_write(4'd6, 32'd0);
      txq.delete();
      strobe_cnt = 0;
      cpu_write(4'd0, 32'd0);
      repeat (4) @(negedge clk);
      read_check("nout0_status", 4'd0, 32'b010);
      cpu_write(4'd5, 32'd0);
      cpu_write(4'd6, 32'd3);
      cpu_write(4'd0, 32'd0);
      repeat (4) @(negedge clk);
      read_check("len0_status", 4'd0, 32'b110);
      check("degenerate_no_strobes", 64'(strobe_cnt), 64'd0);

      // ---------------- weight pointer wrap
      configure(32'h100, 32'hFFFF_FFF0, 32'h2000, 32'h3000, 32'd4, 32'd2, 32'd1);
      txq.delete();
      cpu_write(4'd0, 32'd0);
      wait_done("wrap");
      load_seq_a();
      exp_q[1].data = 32'hFFFF_FFF0;
      exp_q[8].data = 32'h0000_0000;
      check_txns("wrap");
      read_check("wrap_status_err_cleared", 4'd0, 32'b010);

      // ---------------- CPU write during a run stalls until done
      cpu_write(4'd2, 32'h1000);
      txq.delete();
      cpu_write(4'd0, 32'd0);
      @(negedge clk);
      slave_address   = 4'd1;
      slave_writedata = 32'h500;
      slave_write     = 1'b1;
      #1;
      check("cpuwr_stalls", 64'(slave_waitrequest), 64'd1);
      n = 0;
      while (slave_waitrequest && n < 3000) begin
         @(negedge clk);
         n++;
      end
      check("cpuwr_stall_long", 64'(n > 8 && n < 3000), 64'd1);
      @(posedge clk);
      #1;
      slave_write = 1'b0;
      read_check("cpuwr_latched", 4'd1, 32'h500);
      read_check("cpuwr_status", 4'd0, 32'b010);
      load_seq_a();
      check_txns("cpuwr");

      // ---------------- reset during a stalled start write
      cpu_write(4'd1, 32'h100);
      stall_mode = 2;
      txq.delete();
      cpu_write(4'd0, 32'd0);
      n = 0;
      while (!(master_write && master_address == 4'd0) && n < 500) begin
         @(negedge clk);
         n++;
      end
      check("rstmid_reached_wstart", 64'(n < 500), 64'd1);
      repeat (2) @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("rstmid_strobes_drop", 64'({master_write, master_read}), 64'd0);
      check("rstmid_maddr", 64'(master_address), 64'd0);
      check("rstmid_mdata", 64'(master_writedata), 64'd0);
      read_check("rstmid_status", 4'd0, 32'd0);
      read_check("rstmid_bias_cleared", 4'd1, 32'd0);
      read_check("rstmid_count_cleared", 4'd8, 32'd0);
      @(negedge clk);
      stall_mode = 0;
      rst_n      = 1'b1;
      strobe_cnt = 0;
      repeat (8) @(negedge clk);
      check("rstmid_quiet_after_reset", 64'(strobe_cnt), 64'd0);
      configure(32'h100, 32'h1000, 32'h2000, 32'h3000, 32'd4, 32'd1, 32'd1);
      txq.delete();
      cpu_write(4'd0, 32'd0);
      check("replay_first_write_next_cycle", 64'({master_write, master_address}), 64'h11);
      wait_done("replay");
      exp_q.delete();
      for (int i = 0; i < 7; i++) exp_q.push_back(seq_a[i]);
      exp_q.push_back(seq_a[11]);
      check_txns("replay");
      read_check("replay_count", 4'd8, 32'd1);
      read_check("replay_status", 4'd0, 32'b010);

      check("never_write_and_read", 64'(both_err), 64'd0);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
